// File: rtl/register_file.sv
// Architectural register file x0..x31 with per-register ROB rename tags.
// Reads are combinational with a commit bypass; issue, commit and flush update state on the clock.
module register_file #(
    parameter int ROB_INDEX_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,

    input  logic                     iss_valid,
    input  logic [4:0]               iss_rd,
    input  logic [ROB_INDEX_BIT-1:0] iss_rob_id,

    input  logic [4:0]               cm_rd,
    input  logic [31:0]              cm_val,
    input  logic [ROB_INDEX_BIT-1:0] cm_rob_id,

    input  logic [4:0]               rs1_addr,
    output logic [31:0]              rs1_val,
    output logic                     rs1_busy,
    output logic [ROB_INDEX_BIT-1:0] rs1_tag,

    input  logic [4:0]               rs2_addr,
    output logic [31:0]              rs2_val,
    output logic                     rs2_busy,
    output logic [ROB_INDEX_BIT-1:0] rs2_tag
);

    logic [31:0]              val_q [32];
    logic [ROB_INDEX_BIT-1:0] tag_q [32];
    logic [31:0]              busy_q;

    logic cm_active;
    logic cm_tag_match;
    logic iss_active;

    assign cm_active    = (cm_rd != 5'd0);
    assign cm_tag_match = busy_q[cm_rd] && (tag_q[cm_rd] == cm_rob_id);
    assign iss_active   = iss_valid && (iss_rd != 5'd0);

    // Later assignments win: an issue to the same register overrides the commit's busy clear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < 32; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy_in) begin
            if (cm_active) begin
                val_q[cm_rd] <= cm_val;
                if (cm_tag_match) begin
                    busy_q[cm_rd] <= 1'b0;
                end
            end
            if (clear_in) begin
                busy_q <= '0;
            end else if (iss_active) begin
                busy_q[iss_rd] <= 1'b1;
                tag_q[iss_rd]  <= iss_rob_id;
            end
        end
    end

    always_comb begin
        rs1_val  = val_q[rs1_addr];
        rs1_busy = busy_q[rs1_addr];
        rs1_tag  = tag_q[rs1_addr];
        if (rs1_addr == 5'd0) begin
            rs1_val  = '0;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
        end else if (cm_active && (cm_rd == rs1_addr) && cm_tag_match) begin
            rs1_val  = cm_val;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_val  = val_q[rs2_addr];
        rs2_busy = busy_q[rs2_addr];
        rs2_tag  = tag_q[rs2_addr];
        if (rs2_addr == 5'd0) begin
            rs2_val  = '0;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
        end else if (cm_active && (cm_rd == rs2_addr) && cm_tag_match) begin
            rs2_val  = cm_val;
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: rename, commit bypass, stale commit, flush, x0, rdy_in, async reset.
module tb_register_file;

    localparam int RB = 4;

    logic          clk_in;
    logic          rst_in;
    logic          rdy_in;
    logic          clear_in;
    logic          iss_valid;
    logic [4:0]    iss_rd;
    logic [RB-1:0] iss_rob_id;
    logic [4:0]    cm_rd;
    logic [31:0]   cm_val;
    logic [RB-1:0] cm_rob_id;
    logic [4:0]    rs1_addr;
    logic [31:0]   rs1_val;
    logic          rs1_busy;
    logic [RB-1:0] rs1_tag;
    logic [4:0]    rs2_addr;
    logic [31:0]   rs2_val;
    logic          rs2_busy;
    logic [RB-1:0] rs2_tag;

    logic clk_en;
    int   checks;
    int   failures;

    register_file #(.ROB_INDEX_BIT(RB)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rob_id(iss_rob_id),
        .cm_rd(cm_rd), .cm_val(cm_val), .cm_rob_id(cm_rob_id),
        .rs1_addr(rs1_addr), .rs1_val(rs1_val), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag),
        .rs2_addr(rs2_addr), .rs2_val(rs2_val), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag)
    );

    always begin
        #5;
        if (clk_en) clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_ports();
        iss_valid  = 1'b0;
        iss_rd     = '0;
        iss_rob_id = '0;
        cm_rd      = '0;
        cm_val     = '0;
        cm_rob_id  = '0;
        clear_in   = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [RB-1:0] rob);
        iss_valid  = 1'b1;
        iss_rd     = rd;
        iss_rob_id = rob;
        tick();
        idle_ports();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk_in   = 1'b0;
        clk_en   = 1'b0;
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        idle_ports();

        // 1: reset with the clock idle
        #2;
        check("reset_rs1_val", rs1_val, 32'h0);
        check("reset_rs1_busy", {31'b0, rs1_busy}, 32'h0);
        check("reset_rs1_tag", {28'b0, rs1_tag}, 32'h0);
        #3;
        rst_in = 1'b1;
        clk_en = 1'b1;
        #2;

        // 2: rename then commit with bypass
        issue(5'd3, 4'd7);
        rs1_addr = 5'd3;
        #1;
        check("rename_busy", {31'b0, rs1_busy}, 32'h1);
        check("rename_tag", {28'b0, rs1_tag}, 32'h7);
        cm_rd = 5'd3; cm_val = 32'hDEADBEEF; cm_rob_id = 4'd7;
        #1;
        check("bypass_val", rs1_val, 32'hDEADBEEF);
        check("bypass_busy", {31'b0, rs1_busy}, 32'h0);
        tick();
        idle_ports();
        #1;
        check("commit_val", rs1_val, 32'hDEADBEEF);
        check("commit_busy", {31'b0, rs1_busy}, 32'h0);

        // 3: stale commit leaves the younger rename in place
        issue(5'd4, 4'd1);
        issue(5'd4, 4'd2);
        rs1_addr = 5'd4;
        cm_rd = 5'd4; cm_val = 32'h11; cm_rob_id = 4'd1;
        #1;
        check("stale_read_busy", {31'b0, rs1_busy}, 32'h1);
        check("stale_read_val", rs1_val, 32'h0);
        check("stale_read_tag", {28'b0, rs1_tag}, 32'h2);
        tick();
        idle_ports();
        #1;
        check("stale_val", rs1_val, 32'h11);
        check("stale_busy", {31'b0, rs1_busy}, 32'h1);
        check("stale_tag", {28'b0, rs1_tag}, 32'h2);

        // 4: same-cycle commit and issue to one register
        issue(5'd6, 4'd3);
        rs2_addr = 5'd6;
        cm_rd = 5'd6; cm_val = 32'h55; cm_rob_id = 4'd3;
        iss_valid = 1'b1; iss_rd = 5'd6; iss_rob_id = 4'd9;
        #1;
        check("iss_cm_read_val", rs2_val, 32'h55);
        check("iss_cm_read_busy", {31'b0, rs2_busy}, 32'h0);
        tick();
        idle_ports();
        #1;
        check("iss_cm_val", rs2_val, 32'h55);
        check("iss_cm_busy", {31'b0, rs2_busy}, 32'h1);
        check("iss_cm_tag", {28'b0, rs2_tag}, 32'h9);

        // 5: flush with concurrent issue and commit
        issue(5'd1, 4'd10);
        issue(5'd2, 4'd4);
        issue(5'd10, 4'd12);
        clear_in = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd12; iss_rob_id = 4'd5;
        cm_rd = 5'd2; cm_val = 32'h77; cm_rob_id = 4'd4;
        tick();
        idle_ports();
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        check("flush_r1_busy", {31'b0, rs1_busy}, 32'h0);
        check("flush_r2_busy", {31'b0, rs2_busy}, 32'h0);
        check("flush_r2_val", rs2_val, 32'h77);
        rs1_addr = 5'd10; rs2_addr = 5'd12;
        #1;
        check("flush_r10_busy", {31'b0, rs1_busy}, 32'h0);
        check("flush_r12_busy", {31'b0, rs2_busy}, 32'h0);
        rs1_addr = 5'd6; rs2_addr = 5'd4;
        #1;
        check("flush_r6_busy", {31'b0, rs1_busy}, 32'h0);
        check("flush_r4_busy", {31'b0, rs2_busy}, 32'h0);

        // 6: x0 writes are ignored
        iss_valid = 1'b1; iss_rd = 5'd0; iss_rob_id = 4'd3;
        cm_rd = 5'd0; cm_val = 32'h99; cm_rob_id = 4'd3;
        tick();
        idle_ports();
        rs1_addr = 5'd0;
        #1;
        check("x0_val", rs1_val, 32'h0);
        check("x0_busy", {31'b0, rs1_busy}, 32'h0);
        check("x0_tag", {28'b0, rs1_tag}, 32'h0);

        // 6: rdy_in low freezes issue, commit and flush
        issue(5'd9, 4'd2);
        rdy_in = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd8; iss_rob_id = 4'd6;
        cm_rd = 5'd3; cm_val = 32'h1234; cm_rob_id = 4'd0;
        clear_in = 1'b1;
        tick();
        idle_ports();
        rs1_addr = 5'd8; rs2_addr = 5'd9;
        #1;
        check("stall_r8_busy", {31'b0, rs1_busy}, 32'h0);
        check("stall_r9_busy", {31'b0, rs2_busy}, 32'h1);
        rs1_addr = 5'd3;
        #1;
        check("stall_r3_val", rs1_val, 32'hDEADBEEF);
        rdy_in = 1'b1;
        issue(5'd8, 4'd6);
        rs1_addr = 5'd8;
        #1;
        check("resume_r8_busy", {31'b0, rs1_busy}, 32'h1);
        check("resume_r8_tag", {28'b0, rs1_tag}, 32'h6);

        // ROB index 15 must match exactly, not alias
        issue(5'd20, 4'd15);
        rs1_addr = 5'd20;
        cm_rd = 5'd20; cm_val = 32'hA5A5; cm_rob_id = 4'd15;
        #1;
        check("wrap_bypass_busy", {31'b0, rs1_busy}, 32'h0);
        tick();
        idle_ports();
        #1;
        check("wrap_val", rs1_val, 32'hA5A5);

        // asynchronous reset between edges
        rs1_addr = 5'd3; rs2_addr = 5'd8;
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_r3_val", rs1_val, 32'h0);
        check("async_rst_r8_busy", {31'b0, rs2_busy}, 32'h0);
        check("async_rst_r8_tag", {28'b0, rs2_tag}, 32'h0);
        rst_in = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural integer register file (x0..x31) with per-register rename tags for the Tomasulo core.
- Sits between the instruction unit and the reorder buffer. The instruction unit renames destinations at issue and reads source operands (value, or the ROB tag to wait on).
- The reorder buffer retires results into it through the commit port.
- A misprediction flush drops all outstanding renames.

Parameters:
- ROB_INDEX_BIT, 4, width of a ROB entry index (ROB capacity = 2^ROB_INDEX_BIT).

Ports:
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global ready; when low, all state holds
- clear_in  input  1  misprediction flush from ROB
- iss_valid  input  1  instruction issued this cycle with a destination
- iss_rd  input  5  destination register of issued instruction
- iss_rob_id  input  ROB_INDEX_BIT  ROB entry allocated to issued instruction
- cm_rd  input  5  committing destination register; 0 = no commit this cycle
- cm_val  input  32  committed result
- cm_rob_id  input  ROB_INDEX_BIT  ROB entry being committed
- rs1_addr  input  5  source 1 register index
- rs1_val  output  32  source 1 value (valid when rs1_busy=0)
- rs1_busy  output  1  source 1 awaits a ROB result
- rs1_tag  output  ROB_INDEX_BIT  ROB entry producing source 1
- rs2_addr, rs2_val, rs2_busy, rs2_tag: same as rs1_* for source 2

Behaviour:
- State per register i: val[i] (32b), busy[i] (1b), tag[i] (ROB_INDEX_BIT).
- Reset (rst_in=0, asynchronous): all val=0, busy=0, tag=0. Read outputs follow combinationally, so they read 0/0/0.

Read ports (combinational, zero latency):
- Reading x0 returns val=0, busy=0, tag=0, always.
- Commit bypass: if cm_rd!=0, cm_rd==rsN_addr, busy[rsN_addr]=1 and tag[rsN_addr]==cm_rob_id, then rsN_val=cm_val, rsN_busy=0.
- Otherwise the outputs show the stored val/busy/tag.
- Same-cycle issue is NOT visible on the read ports. An instruction whose rd equals its own rs sees the pre-rename state.
- The read ports ignore clear_in and rdy_in.

Sequential update (rdy_in=1, clear_in=0):
- Commit (cm_rd!=0): val[cm_rd] <= cm_val. If busy[cm_rd]=1 and tag[cm_rd]==cm_rob_id, then busy[cm_rd] <= 0. On a tag mismatch (a younger rename exists), the value is written but busy/tag are unchanged.
- Issue (iss_valid=1, iss_rd!=0): busy[iss_rd] <= 1, tag[iss_rd] <= iss_rob_id.
- Issue with iss_rd=0 is ignored; x0 is never written and never busy.
- Issue and commit to the same register in one cycle: the value is written and the issue wins for busy/tag (busy=1, tag=iss_rob_id).

Flush (rdy_in=1, clear_in=1):
- All busy <= 0.
- The issue port is ignored that cycle.
- A commit presented that cycle still writes val (it is architectural).
- Tags need not be cleared.

Other conditions:
- rdy_in=0: no state change regardless of other inputs; clear_in is also ignored.
- Reset asserted mid-operation overrides everything immediately.
- ROB index wrap-around needs no special handling; comparison is exact equality on ROB_INDEX_BIT bits.

Test Plan:
1. Reset then read: pulse rst_in low with clk idle, rs1_addr=5 -> rs1_val=0, rs1_busy=0 without any clock edge.
2. Rename then commit: issue rd=3, rob=7; next cycle rs1_addr=3 -> busy=1, tag=7. Commit rd=3, val=0xDEADBEEF, rob=7 -> same-cycle rs1_val=0xDEADBEEF, busy=0. After the edge: stored val=0xDEADBEEF, busy=0.
3. Stale commit: issue rd=4 rob=1, then rd=4 rob=2. Commit rd=4 val=0x11 rob=1 -> val[4]=0x11, busy=1, tag=2, and the read port shows busy=1 during that commit.
4. Same-cycle issue+commit: busy[6]=1 tag=3. In one cycle, commit rd=6 val=0x55 rob=3 and issue rd=6 rob=9 -> after the edge val=0x55, busy=1, tag=9. The read port that cycle shows val=0x55, busy=0.
5. Flush: registers 1, 2, 10 busy; assert clear_in with issue rd=12 rob=5 and commit rd=2 val=0x77 matching tag -> all busy=0, val[2]=0x77, reg 12 not busy.
6. x0 and rdy_in: issue rd=0 and commit rd=0 -> x0 reads 0, not busy. With rdy_in=0, issue rd=8 -> busy[8] stays 0. Raising rdy_in resumes normal operation.
